nios_system_pio_gen: RTL and testbench
======================================

// Module: nios_system_pio_gen
// PURPOSE
//  Parametrised general-purpose PIO Avalon-MM slave for the Nios system; generational successor to the fixed 8-bit input-only PIO.
//  Per-bit direction, output register with atomic set/clear, input synchronisation, edge capture and a maskable IRQ.
//  Sits between the Avalon interconnect and board pins (switches/keys/LEDs); pin tristating is done at top level using oe_port.
// PARAMETERS
//  WIDTH        8   number of PIO bits, 1..32
//  EDGE_TYPE    0   capture edge: 0 rising, 1 falling, 2 any
//  IRQ_TYPE     1   0 level (sync input & mask), 1 edge (edgecapture & mask)
//  OUT_RESET    0   reset value of output data register (WIDTH bits)
//  DIR_RESET    0   reset value of direction register (1 = output)
//  SYNC_STAGES  2   input synchroniser depth, 2..3
// PORTS
//  clk        in   1      system clock; all logic on rising edge
//  reset_n    in   1      asynchronous active-low reset; released synchronously upstream
//  address    in   3      word address (register map below)
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe, qualified by chipselect
//  writedata  in   32     write data; bits [31:WIDTH] ignored
//  readdata   out  32     registered read data; bits [31:WIDTH] always 0
//  irq        out  1      registered interrupt request, active high
//  in_port    in   WIDTH  asynchronous pin inputs
//  out_port   out  WIDTH  output data register
//  oe_port    out  WIDTH  direction register (1 = drive pin)
// BEHAVIOUR
//  Register map (R = read, W = write):
//   0 DATA  R: per bit, dir ? out_reg : in_sync   W: out_reg <= wd
//   1 DIR   R/W direction register
//   2 MASK  R/W irq mask
//   3 EDGE  R edgecapture; W: write-1-to-clear (bits written 0 unchanged)
//   4 SET   W: out_reg <= out_reg | wd;  R: 0
//   5 CLR   W: out_reg <= out_reg & ~wd; R: 0
//   6,7     R: 0; W ignored
//  Write occurs when chipselect && !write_n; single cycle, no wait states.
//  readdata <= mux(address) every cycle (no read strobe); valid 1 clk after address; no read side effects.
//  Input path: in_port -> SYNC_STAGES flops -> in_sync; one more flop -> in_prev.
//   rise = in_sync & ~in_prev; fall = ~in_sync & in_prev; edge selected by EDGE_TYPE.
//  Edge arming: counter of SYNC_STAGES+1 cycles runs from reset release; edges ignored until armed,
//   so a pin already high at reset never sets EDGE. Counter saturates; re-zeroed only by reset.
//  EDGE bit: set on detected edge (input bits only, dir=0); cleared by write-1.
//   Same-cycle edge and clear on the same bit: set wins (bit = 1 next cycle).
//  irq <= |(src & MASK), src = edgecapture (IRQ_TYPE 1) or in_sync & ~dir (IRQ_TYPE 0); 1 clk after the source.
//  Direction change 1->0: the bit immediately reads in_sync; no edge is generated by the switch itself.
//  Reset (any time, including mid-access): out_reg = OUT_RESET, dir = DIR_RESET, MASK = 0, EDGE = 0,
//   synchroniser and in_prev = 0, arm counter = 0, readdata = 0, irq = 0. Any in-flight write is lost.
//  out_port = out_reg, oe_port = dir, both directly from registers (no combinational path from bus).
// TESTING
//  1 Reset with in_port=8'hFF, release, wait 10 clks -> EDGE reads 0, irq 0, DATA reads 8'hFF, out_port=OUT_RESET.
//  2 DIR=8'h0F, DATA=8'hA5, SET 8'h10, CLR 8'h01 -> out_port=8'hB4, oe_port=8'h0F, DATA read low nibble = 4'h4.
//  3 MASK=8'h01, rising edge on in_port[0] -> EDGE=8'h01 and irq=1 exactly SYNC_STAGES+2 clks after pin change.
//  4 Write EDGE=8'h01 same cycle a new edge hits bit 0 -> EDGE stays 8'h01, irq stays 1; next clear -> irq 0 after 1 clk.
//  5 IRQ_TYPE=0, MASK=8'h80, hold in_port[7]=1 then 0 -> irq follows with SYNC_STAGES+1 clk delay, no latching.
//  6 Assert reset_n low mid-write of DATA=8'h3C -> out_port=OUT_RESET immediately (async), readdata=0, irq=0.

Source files
------------

// File: rtl/nios_system_pio_gen.sv
// Parametrised Avalon-MM PIO slave: per-bit direction, set/clear output,
// synchronised inputs with armed edge capture and a maskable interrupt.
module nios_system_pio_gen #(
  parameter int          WIDTH       = 8,
  parameter int          EDGE_TYPE   = 0,
  parameter int          IRQ_TYPE    = 1,
  parameter logic [31:0] OUT_RESET   = '0,
  parameter logic [31:0] DIR_RESET   = '0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port
);

  localparam int ARM = SYNC_STAGES + 1;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;
  logic [2:0]       arm_cnt;
  logic             armed;

  logic [WIDTH-1:0] out_reg, out_next;
  logic [WIDTH-1:0] dir_reg, dir_next;
  logic [WIDTH-1:0] mask_reg, mask_next;
  logic [WIDTH-1:0] edge_reg, edge_next;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rise, fall, sel, det;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd;
  logic             wr;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign armed     = (arm_cnt == 3'(ARM));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      in_prev <= '0;
      arm_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-1:0], in_port};
      in_prev <= in_sync;
      if (!armed)
        arm_cnt <= arm_cnt + 3'd1;
    end
  end

  // Edges are ignored until the synchroniser has flushed after reset
  always_comb begin
    rise = in_sync & ~in_prev;
    fall = ~in_sync & in_prev;
    if (EDGE_TYPE == 0)
      sel = rise;
    else if (EDGE_TYPE == 1)
      sel = fall;
    else
      sel = rise | fall;
    det = armed ? (sel & ~dir_reg) : '0;
  end

  always_comb begin
    out_next  = out_reg;
    dir_next  = dir_reg;
    mask_next = mask_reg;
    clr       = '0;
    unique case (1'b1)
      wr && address == 3'd0: out_next  = wd;
      wr && address == 3'd1: dir_next  = wd;
      wr && address == 3'd2: mask_next = wd;
      wr && address == 3'd3: clr       = wd;
      wr && address == 3'd4: out_next  = out_reg | wd;
      wr && address == 3'd5: out_next  = out_reg & ~wd;
      default: ;
    endcase
    edge_next = (edge_reg & ~clr) | det;
  end

  always_comb begin
    rd = '0;
    case (address)
      3'd0:    rd[WIDTH-1:0] = (dir_reg & out_reg) | (~dir_reg & in_sync);
      3'd1:    rd[WIDTH-1:0] = dir_reg;
      3'd2:    rd[WIDTH-1:0] = mask_reg;
      3'd3:    rd[WIDTH-1:0] = edge_reg;
      default: rd = '0;
    endcase
  end

  assign src = (IRQ_TYPE == 1) ? edge_reg : (in_sync & ~dir_reg);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_reg  <= OUT_RESET[WIDTH-1:0];
      dir_reg  <= DIR_RESET[WIDTH-1:0];
      mask_reg <= '0;
      edge_reg <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      out_reg  <= out_next;
      dir_reg  <= dir_next;
      mask_reg <= mask_next;
      edge_reg <= edge_next;
      readdata <= rd;
      irq      <= |(src & mask_reg);
    end
  end

  assign out_port = out_reg;
  assign oe_port  = dir_reg;

endmodule

// File: tb/tb_nios_system_pio_gen.sv
// Bench for nios_system_pio_gen: edge-IRQ and level-IRQ instances on one bus,
// table vectors, timing sequences and random traffic against a reference model.
module tb_nios_system_pio_gen;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata, readdata_l;
  logic        irq, irq_l;
  logic [7:0]  out_port, out_port_l;
  logic [7:0]  oe_port, oe_port_l;

  always #5 clk = ~clk;

  nios_system_pio_gen #(.WIDTH(8), .IRQ_TYPE(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .in_port(in_port),
    .out_port(out_port), .oe_port(oe_port)
  );

  nios_system_pio_gen #(.WIDTH(8), .IRQ_TYPE(0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata_l), .irq(irq_l), .in_port(in_port),
    .out_port(out_port_l), .oe_port(oe_port_l)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pin history queue, registers as plain variables
  logic [7:0]  m_out, m_dir, m_mask, m_edge;
  logic [31:0] m_rd;
  logic        m_irq, m_irql;
  int          m_n;
  logic [7:0]  hist[$];

  task automatic model_reset();
    m_out = 8'h00; m_dir = 8'h00; m_mask = 8'h00; m_edge = 8'h00;
    m_rd = 32'h0; m_irq = 1'b0; m_irql = 1'b0; m_n = 0;
    hist = {};
    repeat (S + 1) hist.push_back(8'h00);
  endtask

  task automatic model_edge();
    logic [7:0] sy, pv, det, wd;
    logic w;
    sy = hist[S-1];
    pv = hist[S];
    w  = chipselect && !write_n;
    wd = writedata[7:0];
    case (address)
      3'd0:    m_rd = {24'h0, (m_dir & m_out) | (~m_dir & sy)};
      3'd1:    m_rd = {24'h0, m_dir};
      3'd2:    m_rd = {24'h0, m_mask};
      3'd3:    m_rd = {24'h0, m_edge};
      default: m_rd = 32'h0;
    endcase
    m_irq  = |(m_edge & m_mask);
    m_irql = |(sy & ~m_dir & m_mask);
    det = (m_n >= S + 1) ? (sy & ~pv & ~m_dir) : 8'h00;
    if (w && address == 3'd3) m_edge = m_edge & ~wd;
    m_edge = m_edge | det;
    if (w) begin
      case (address)
        3'd0: m_out = wd;
        3'd1: m_dir = wd;
        3'd2: m_mask = wd;
        3'd4: m_out = m_out | wd;
        3'd5: m_out = m_out & ~wd;
        default: ;
      endcase
    end
    hist.push_front(in_port);
    void'(hist.pop_back());
    if (m_n < 1000) m_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge();
    #1;
    chk("m_readdata", readdata, m_rd);
    chk("m_readdata_l", readdata_l, m_rd);
    chk("m_irq", {31'h0, irq}, {31'h0, m_irq});
    chk("m_irq_l", {31'h0, irq_l}, {31'h0, m_irql});
    chk("m_out_port", {24'h0, out_port}, {24'h0, m_out});
    chk("m_out_port_l", {24'h0, out_port_l}, {24'h0, m_out});
    chk("m_oe_port", {24'h0, oe_port}, {24'h0, m_dir});
    chk("m_oe_port_l", {24'h0, oe_port_l}, {24'h0, m_dir});
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        w;
    logic [31:0] wd;
    logic [7:0]  pin;
    logic [31:0] exp;
    logic        c;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{3'd1, 1'b1, 32'h0000_000F, 8'h00, 32'h0, 1'b0};
    tbl[1] = '{3'd0, 1'b1, 32'hFFFF_FFA5, 8'h00, 32'h0, 1'b0};
    tbl[2] = '{3'd4, 1'b1, 32'h0000_0010, 8'h00, 32'h0, 1'b0};
    tbl[3] = '{3'd5, 1'b1, 32'h0000_0001, 8'h00, 32'h0, 1'b0};
    tbl[4] = '{3'd1, 1'b0, 32'h0, 8'h00, 32'h0000_000F, 1'b1};
    tbl[5] = '{3'd0, 1'b0, 32'h0, 8'h00, 32'h0000_0004, 1'b1};
    tbl[6] = '{3'd2, 1'b0, 32'h0, 8'h00, 32'h0000_0000, 1'b1};
    tbl[7] = '{3'd3, 1'b0, 32'h0, 8'h00, 32'h0000_0000, 1'b1};
    tbl[8] = '{3'd4, 1'b0, 32'h0, 8'h00, 32'h0000_0000, 1'b1};

    model_reset();
    reset_n   = 1'b0;
    address   = 3'd3;
    writedata = 32'h0;
    in_port   = 8'hFF;
    bus_idle();

    // Pin already high across reset must not set EDGE
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("t1_edge_rd", readdata, 32'h0);
    chk("t1_irq", {31'h0, irq}, 32'h0);
    address = 3'd0;
    tick();
    chk("t1_data_rd", readdata, 32'h0000_00FF);
    chk("t1_out_port", {24'h0, out_port}, 32'h0);

    // Direction, data, set and clear
    for (int i = 0; i < 9; i++) begin
      in_port    = tbl[i].pin;
      address    = tbl[i].addr;
      chipselect = tbl[i].w;
      write_n    = ~tbl[i].w;
      writedata  = tbl[i].wd;
      tick();
      bus_idle();
      if (tbl[i].c) chk("tbl_rd", readdata, tbl[i].exp);
    end
    chk("t2_out_port", {24'h0, out_port}, 32'h0000_00B4);
    chk("t2_oe_port", {24'h0, oe_port}, 32'h0000_000F);

    // Rising edge on bit 0: EDGE and irq S+2 clocks after the pin
    wr(3'd1, 32'h00);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    address = 3'd3;
    in_port = 8'h01;
    for (int i = 1; i <= S + 2; i++) begin
      tick();
      if (i < S + 2) chk("t3_irq_early", {31'h0, irq}, 32'h0);
    end
    chk("t3_irq", {31'h0, irq}, 32'h1);
    chk("t3_edge_rd", readdata, 32'h1);

    // Clear in the same cycle as a new edge: set wins
    in_port = 8'h00;
    repeat (S + 2) tick();
    in_port = 8'h01;
    repeat (S) tick();
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h1;
    tick();
    bus_idle();
    tick();
    chk("t4_hold_irq", {31'h0, irq}, 32'h1);
    chk("t4_hold_edge", readdata, 32'h1);
    wr(3'd3, 32'h1);
    tick();
    chk("t4_clr_irq", {31'h0, irq}, 32'h0);
    chk("t4_clr_edge", readdata, 32'h0);

    // Level irq follows the synchronised pin without latching
    wr(3'd2, 32'h80);
    in_port = 8'h81;
    for (int i = 1; i <= S + 1; i++) begin
      tick();
      chk("t5_rise_irq_l", {31'h0, irq_l}, (i == S + 1) ? 32'h1 : 32'h0);
    end
    in_port = 8'h01;
    for (int i = 1; i <= S + 1; i++) begin
      tick();
      chk("t5_fall_irq_l", {31'h0, irq_l}, (i == S + 1) ? 32'h0 : 32'h1);
    end

    // Asynchronous reset in the middle of a DATA write
    address    = 3'd0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h3C;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_out_port", {24'h0, out_port}, 32'h0);
    chk("t6_readdata", readdata, 32'h0);
    chk("t6_irq", {31'h0, irq}, 32'h0);
    chk("t6_oe_port", {24'h0, oe_port}, 32'h0);
    repeat (2) tick();
    bus_idle();
    reset_n = 1'b1;
    tick();
    chk("t6_after_out", {24'h0, out_port}, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      writedata  = $urandom;
      if ($urandom_range(0, 2) == 0)
        in_port = in_port ^ 8'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
